// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencer and instruction-fetch controller.
// Owns the fetch PC, issues one imem request at a time over valid/ready,
// buffers the returned word for IF/ID, and applies stalls, branch/jump
// redirects and trap redirects (wrong-path responses are discarded).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall_i             hazard freeze: blocks new requests and IF handoff
//   redirect_valid/_pc  taken branch/jump target from EX
//   trap_valid          trap redirect to TRAP_VECTOR (wins over redirect)
//   imem_req_*          fetch request channel (valid/ready/addr)
//   imem_rsp_*          fetch response (valid/data)
//   if_valid/pc/instr   fetched instruction to IF/ID, if_ready accepts it
//   pc                  next address to be fetched
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic [31:0] pc
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic              kill_q, kill_d;
    logic              req_committed_q, req_committed_d;
    logic              if_valid_q, if_valid_d;

    logic              redir_c;
    logic [XLEN-1:0]   redir_target_c;
    logic              req_valid_c;
    logic [XLEN-1:0]   req_addr_c;
    logic              req_fire_c;

    // Redirect target; trap wins, branch targets are word-aligned.
    assign redir_c        = trap_valid | redirect_valid;
    assign redir_target_c = trap_valid ? TRAP_VECTOR : (redirect_pc & ~XLEN'(3));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (req_fire_c) state_d = WAIT;
            WAIT: if (imem_rsp_valid) state_d = (kill_q || redir_c) ? REQ : HOLD;
            HOLD: if (redir_c || (if_ready && !stall_i)) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Request channel: once asserted the request (and its address) is held
    // until accepted, regardless of stall or a redirect moving pc_q.
    always_comb begin
        req_valid_c = 1'b0;
        req_addr_c  = pc_q;
        if (state_q == REQ) begin
            req_valid_c = !stall_i || req_committed_q;
            req_addr_c  = req_committed_q ? req_addr_q : pc_q;
        end
        req_fire_c = req_valid_c && imem_req_ready;
    end

    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = req_addr_c;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign pc             = pc_q;

    // Datapath next-state: pc sequencing, kill tracking, IF buffer.
    always_comb begin
        pc_d            = pc_q;
        req_pc_d        = req_pc_q;
        req_addr_d      = req_addr_q;
        if_pc_d         = if_pc_q;
        if_instr_d      = if_instr_q;
        kill_d          = kill_q;
        req_committed_d = req_committed_q;
        if_valid_d      = if_valid_q;
        case (state_q)
            IDLE: begin
                kill_d          = 1'b0;
                req_committed_d = 1'b0;
            end
            REQ: begin
                if (req_fire_c) begin
                    req_pc_d        = req_addr_c;
                    req_committed_d = 1'b0;
                    // A pending kill means pc_q already holds the redirect target.
                    pc_d            = kill_q ? pc_q : pc_q + XLEN'(4);
                end else if (req_valid_c) begin
                    req_committed_d = 1'b1;
                    req_addr_d      = req_addr_c;
                end
                if (redir_c) begin
                    pc_d = redir_target_c;
                    if (req_valid_c) kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (!kill_q && !redir_c) begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = req_pc_q;
                        if_valid_d = 1'b1;
                    end
                end else if (redir_c) begin
                    kill_d = 1'b1;
                end
                if (redir_c) pc_d = redir_target_c;
            end
            HOLD: begin
                if (redir_c) begin
                    pc_d       = redir_target_c;
                    if_valid_d = 1'b0;
                end else if (if_ready && !stall_i) begin
                    if_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q            <= RESET_VECTOR;
            req_pc_q        <= '0;
            req_addr_q      <= '0;
            if_pc_q         <= '0;
            if_instr_q      <= NOP_INSTR;
            kill_q          <= 1'b0;
            req_committed_q <= 1'b0;
            if_valid_q      <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            req_pc_q        <= req_pc_d;
            req_addr_q      <= req_addr_d;
            if_pc_q         <= if_pc_d;
            if_instr_q      <= if_instr_d;
            kill_q          <= kill_d;
            req_committed_q <= req_committed_d;
            if_valid_q      <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a simple variable-latency imem model.
// Instruction word returned for address a is a ^ 32'h1234_0013.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b1;
    logic [31:0] pc;

    int total = 0;
    int bad   = 0;

    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_0013;
    endfunction

    // Memory: one response per accepted request, 'lat' cycles later.
    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (cnt == 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_word(pend_addr);
        end
        if (cnt != 0) cnt <= cnt - 1;
        if (imem_req_valid && imem_req_ready) begin
            if (lat <= 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(imem_req_addr);
            end else begin
                pend_addr <= imem_req_addr;
                cnt       <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next instruction handed to IF/ID and check it.
    task automatic wait_ifv(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!if_valid && n < 40);
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_pc"}, if_pc, exp_pc);
        chk({tag, "_instr"}, if_instr, exp_instr);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // 1: sequential fetch
        rst = 1'b1;
        tick();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h0);
        wait_ifv("t1_i0", 32'h0, 32'h1234_0013);
        wait_ifv("t1_i1", 32'h4, 32'h1234_0017);

        // 2: IF/ID back-pressure in HOLD
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_if_valid", 32'(if_valid), 32'd1);
            chk("t2_if_pc", if_pc, 32'h4);
            chk("t2_if_instr", if_instr, 32'h1234_0017);
            chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        end
        chk("t2_pc", pc, 32'h8);

        // 3: imem not ready, stall rising mid-wait
        if_ready       = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        chk("t3_if_valid", 32'(if_valid), 32'd0);
        chk("t3_req_valid0", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr0", imem_req_addr, 32'h8);
        tick();
        stall_i = 1'b1;
        #1;
        chk("t3_req_valid1", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr1", imem_req_addr, 32'h8);
        tick();
        chk("t3_req_valid2", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr2", imem_req_addr, 32'h8);
        chk("t3_pc_held", pc, 32'h8);
        imem_req_ready = 1'b1;
        tick();
        stall_i = 1'b0;
        chk("t3_pc_adv", pc, 32'hC);
        wait_ifv("t3_i2", 32'h8, 32'h1234_001B);

        // 4: redirect during WAIT, late response dropped
        lat = 3;
        tick();
        chk("t4_req_addr", imem_req_addr, 32'hC);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        chk("t4_pc", pc, 32'h200);
        chk("t4_if_valid", 32'(if_valid), 32'd0);
        if_ready = 1'b0;
        wait_ifv("t4_i", 32'h200, 32'h1234_0213);

        // 5: trap + redirect together in HOLD
        tick();
        chk("t5_hold_valid", 32'(if_valid), 32'd1);
        trap_valid     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        chk("t5_if_valid", 32'(if_valid), 32'd0);
        chk("t5_pc", pc, 32'h100);
        wait_ifv("t5_i", 32'h100, 32'h1234_0113);

        // 6: wrap at top of address space, then reset during WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        chk("t6_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        wait_ifv("t6_itop", 32'hFFFF_FFFC, 32'hEDCB_FFEF);
        chk("t6_pc_wrap", pc, 32'h0);
        lat = 3;
        tick();
        chk("t6_req_addr0", imem_req_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rst_pc", pc, 32'h0);
        chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
        chk("t6_rst_if_instr", if_instr, 32'h0000_0013);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        rst = 1'b1;
        lat = 1;
        wait_ifv("t6_after_rst0", 32'h0, 32'h1234_0013);
        wait_ifv("t6_after_rst1", 32'h4, 32'h1234_0017);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
